ex_operand_stage: RTL and testbench
===================================

EX_OPERAND_STAGE -- requirements
Module: ex_operand_stage

Interface
- REQ-001: Parameter N_BITS, default 32, data width of operands and results.
- REQ-002: Parameter CNT_BITS, default 16, width of the bubble counter.
- REQ-003: clk  input  1  the single clock; all state updates on its rising edge.
- REQ-004: reset  input  1  asynchronous, active-low reset.
- REQ-005: in_valid  input  1  a decoded instruction is presented.
- REQ-006: in_ready  output  1  the stage accepts the instruction this cycle.
- REQ-007: in_alu_op  input  4  ALU operation code (AND=0, OR=1, NOR=2, ADD=3, SLL=4, SRL=5, ADDI=6, ORI=7, LUI=8, ANDI=9).
- REQ-008: in_rs_data, in_rt_data  input  N_BITS  register-file read data.
- REQ-009: in_rs_addr, in_rt_addr, in_rd_addr  input  5  source and destination register numbers.
- REQ-010: in_imm  input  N_BITS  already-extended immediate.
- REQ-011: in_shamt  input  5  shift amount.
- REQ-012: in_alu_src  input  1  1 selects in_imm as operand B.
- REQ-013: in_reg_write  input  1  the instruction writes rd.
- REQ-014: flush  input  1  discard held and incoming instruction.
- REQ-015: exmem_reg_write, exmem_rd, exmem_result  input  1/5/N_BITS  EX/MEM forwarding source.
- REQ-016: memwb_reg_write, memwb_rd, memwb_result  input  1/5/N_BITS  MEM/WB forwarding source.
- REQ-017: out_valid  output  1  the registered outputs hold a valid instruction.
- REQ-018: out_ready  input  1  the downstream ALU/EX stage consumes this cycle.
- REQ-019: ALUOperation  output  4  registered operation code.
- REQ-020: A, B  output  N_BITS  registered ALU operands.
- REQ-021: ALUShamt  output  5  registered shift amount.
- REQ-022: out_rd_addr, out_reg_write  output  5/1  registered write-back tag.
- REQ-023: bubble_count  output  CNT_BITS  cycles in which out_valid=0 or the output was held by out_ready=0.

Function
- REQ-024: The stage shall assert in_ready = (!out_valid || out_ready) && !flush.
- REQ-025: When in_valid && in_ready, the stage shall load all output registers on the next edge and set out_valid=1.
- REQ-026: When out_valid && out_ready and no new load occurs, the stage shall clear out_valid on the next edge.
- REQ-027: When out_valid && !out_ready, the stage shall hold every output register unchanged.
- REQ-028: When flush=1, the stage shall clear out_valid on the next edge and shall drop in_valid that cycle; flush takes priority over load and hold.
- REQ-029: The forwarded value for a source register shall be exmem_result if exmem_reg_write && exmem_rd==addr && addr!=0.
- REQ-030: Otherwise it shall be memwb_result if memwb_reg_write && memwb_rd==addr && addr!=0; otherwise it shall be the register-file data.
- REQ-031: When EX/MEM and MEM/WB both match, EX/MEM shall win.
- REQ-032: For SLL and SRL, the stage shall load A with forwarded rt and B with forwarded rt.
- REQ-033: For all other operations, the stage shall load A with forwarded rs.
- REQ-034: For all other operations, B shall be in_imm when in_alu_src=1 and forwarded rt otherwise.
- REQ-035: For LUI, B shall be in_imm regardless of in_alu_src.
- REQ-036: Forwarding shall be evaluated only at load time; held outputs shall not be re-forwarded.
- REQ-037: bubble_count shall increment by 1 per counted cycle and saturate at all-ones, with no wrap.
- REQ-038: Latency shall be one cycle from acceptance to out_valid.

Reset
- REQ-039: While reset=0, regardless of clk, the stage shall force out_valid=0, ALUOperation=0, A=0, B=0, ALUShamt=0, out_rd_addr=0, out_reg_write=0, and bubble_count=0.
- REQ-040: Reset asserted mid-hold shall discard the held instruction.
- REQ-041: The first load shall be possible on the first rising edge after reset deasserts.

Verification
- REQ-042: Basic load: ADD, rs=3 (0x10), rt=4 (0x20), no forwarding, out_ready=1 -> next cycle out_valid=1, A=0x10, B=0x20, ALUOperation=3.
- REQ-043: Forwarding priority: rs=5 with exmem_rd=5 (0xAAAA) and memwb_rd=5 (0xBBBB), both writes enabled -> A=0xAAAA; with rs=0 in the same setup -> A=in_rs_data.
- REQ-044: Backpressure: out_ready=0 for 3 cycles while in_valid=1 -> in_ready=0, outputs stable, bubble_count +3; then out_ready=1 -> next instruction loads.
- REQ-045: Flush: flush=1 with in_valid=1 and out_valid=1 -> next cycle out_valid=0, and the incoming instruction never appears.
- REQ-046: Shift and LUI routing: SLL with rt=0x1, shamt=4 -> A=0x1, ALUShamt=4; LUI with in_imm=0x1234, in_alu_src=0 -> B=0x1234.
- REQ-047: Saturation and reset: with CNT_BITS=4, 20 idle cycles -> bubble_count=0xF; asynchronous reset pulse mid-cycle -> all outputs 0 immediately.

Source files
------------

// File: rtl/ex_operand_stage.sv
// EX operand stage: resolves forwarding for rs/rt, routes ALU operands and
// registers the EX payload behind a one-deep valid/ready handshake.

// One forwarding mux per source register; EX/MEM beats MEM/WB, r0 never forwards.
module ex_fwd_mux #(
  parameter int N_BITS = 32
) (
  input  logic [4:0]        addr,
  input  logic [N_BITS-1:0] rf_data,
  input  logic              exmem_reg_write,
  input  logic [4:0]        exmem_rd,
  input  logic [N_BITS-1:0] exmem_result,
  input  logic              memwb_reg_write,
  input  logic [4:0]        memwb_rd,
  input  logic [N_BITS-1:0] memwb_result,
  output logic [N_BITS-1:0] fwd
);
  // youngest producer wins
  always_comb begin
    fwd = rf_data;
    if (exmem_reg_write && exmem_rd == addr && addr != 5'd0)      fwd = exmem_result;
    else if (memwb_reg_write && memwb_rd == addr && addr != 5'd0) fwd = memwb_result;
  end
endmodule

module ex_operand_stage #(
  parameter int N_BITS   = 32,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [3:0]          in_alu_op,
  input  logic [N_BITS-1:0]   in_rs_data,
  input  logic [N_BITS-1:0]   in_rt_data,
  input  logic [4:0]          in_rs_addr,
  input  logic [4:0]          in_rt_addr,
  input  logic [4:0]          in_rd_addr,
  input  logic [N_BITS-1:0]   in_imm,
  input  logic [4:0]          in_shamt,
  input  logic                in_alu_src,
  input  logic                in_reg_write,
  input  logic                flush,
  input  logic                exmem_reg_write,
  input  logic [4:0]          exmem_rd,
  input  logic [N_BITS-1:0]   exmem_result,
  input  logic                memwb_reg_write,
  input  logic [4:0]          memwb_rd,
  input  logic [N_BITS-1:0]   memwb_result,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [3:0]          ALUOperation,
  output logic [N_BITS-1:0]   A,
  output logic [N_BITS-1:0]   B,
  output logic [4:0]          ALUShamt,
  output logic [4:0]          out_rd_addr,
  output logic                out_reg_write,
  output logic [CNT_BITS-1:0] bubble_count
);
  localparam logic [3:0] OP_SLL = 4'd4;
  localparam logic [3:0] OP_SRL = 4'd5;
  localparam logic [3:0] OP_LUI = 4'd8;

  typedef struct packed {
    logic [3:0]        op;
    logic [N_BITS-1:0] a;
    logic [N_BITS-1:0] b;
    logic [4:0]        shamt;
    logic [4:0]        rd;
    logic              rw;
  } ex_req_t;

  // index 0 = rs, 1 = rt
  logic [1:0][4:0]        src_addr;
  logic [1:0][N_BITS-1:0] src_data;
  logic [1:0][N_BITS-1:0] src_fwd;
  logic [1:0]             vld_pipe;   // [0] load this cycle, [1] registered valid
  ex_req_t                nxt, held;
  logic                   is_shift;

  assign src_addr = {in_rt_addr, in_rs_addr};
  assign src_data = {in_rt_data, in_rs_data};

  for (genvar s = 0; s < 2; s++) begin : g_fwd
    ex_fwd_mux #(.N_BITS(N_BITS)) u_fwd (
      .addr           (src_addr[s]),
      .rf_data        (src_data[s]),
      .exmem_reg_write(exmem_reg_write),
      .exmem_rd       (exmem_rd),
      .exmem_result   (exmem_result),
      .memwb_reg_write(memwb_reg_write),
      .memwb_rd       (memwb_rd),
      .memwb_result   (memwb_result),
      .fwd            (src_fwd[s])
    );
  end

  assign in_ready    = (!vld_pipe[1] || out_ready) && !flush;
  assign vld_pipe[0] = in_valid && in_ready;
  assign is_shift    = (in_alu_op == OP_SLL) || (in_alu_op == OP_SRL);

  // operand routing; shifts take the shifted value from rt on both ports
  always_comb begin
    nxt       = '0;
    nxt.op    = in_alu_op;
    nxt.shamt = in_shamt;
    nxt.rd    = in_rd_addr;
    nxt.rw    = in_reg_write;
    if (is_shift) begin
      nxt.a = src_fwd[1];
      nxt.b = src_fwd[1];
    end else begin
      nxt.a = src_fwd[0];
      nxt.b = (in_alu_src || in_alu_op == OP_LUI) ? in_imm : src_fwd[1];
    end
  end

  // payload register: flush > load > drain; held data is never re-forwarded
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_pipe[1] <= 1'b0;
      held        <= '0;
    end else if (flush) begin
      vld_pipe[1] <= 1'b0;
    end else if (vld_pipe[0]) begin
      vld_pipe[1] <= 1'b1;
      held        <= nxt;
    end else if (vld_pipe[1] && out_ready) begin
      vld_pipe[1] <= 1'b0;
    end
  end

  // saturating count of cycles where nothing was handed downstream
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) bubble_count <= '0;
    else if (!(vld_pipe[1] && out_ready) && bubble_count != '1)
      bubble_count <= bubble_count + CNT_BITS'(1);
  end

  assign out_valid     = vld_pipe[1];
  assign ALUOperation  = held.op;
  assign A             = held.a;
  assign B             = held.b;
  assign ALUShamt      = held.shamt;
  assign out_rd_addr   = held.rd;
  assign out_reg_write = held.rw;
endmodule

// File: tb/tb_ex_operand_stage.sv
// Scoreboard bench for ex_operand_stage: directed scenarios plus random traffic.
module tb_ex_operand_stage;
  localparam int N = 32;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         in_valid, in_ready, in_alu_src, in_reg_write, flush, out_ready;
  logic [3:0]   in_alu_op;
  logic [N-1:0] in_rs_data, in_rt_data, in_imm;
  logic [4:0]   in_rs_addr, in_rt_addr, in_rd_addr, in_shamt;
  logic         exmem_reg_write, memwb_reg_write;
  logic [4:0]   exmem_rd, memwb_rd;
  logic [N-1:0] exmem_result, memwb_result;
  logic         out_valid, out_reg_write;
  logic [3:0]   ALUOperation;
  logic [N-1:0] A, B;
  logic [4:0]   ALUShamt, out_rd_addr;
  logic [15:0]  bubble_count;
  // small-counter instance for saturation
  logic         q4_in_ready, q4_out_valid, q4_out_reg_write;
  logic [3:0]   q4_op;
  logic [N-1:0] q4_a, q4_b;
  logic [4:0]   q4_shamt, q4_rd;
  logic [3:0]   q4_bubble;

  ex_operand_stage #(.N_BITS(N), .CNT_BITS(16)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_alu_op(in_alu_op), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_rd_addr(in_rd_addr),
    .in_imm(in_imm), .in_shamt(in_shamt), .in_alu_src(in_alu_src),
    .in_reg_write(in_reg_write), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .out_valid(out_valid), .out_ready(out_ready), .ALUOperation(ALUOperation),
    .A(A), .B(B), .ALUShamt(ALUShamt), .out_rd_addr(out_rd_addr),
    .out_reg_write(out_reg_write), .bubble_count(bubble_count)
  );

  ex_operand_stage #(.N_BITS(N), .CNT_BITS(4)) dut4 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(q4_in_ready),
    .in_alu_op(in_alu_op), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
    .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_rd_addr(in_rd_addr),
    .in_imm(in_imm), .in_shamt(in_shamt), .in_alu_src(in_alu_src),
    .in_reg_write(in_reg_write), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .out_valid(q4_out_valid), .out_ready(out_ready), .ALUOperation(q4_op),
    .A(q4_a), .B(q4_b), .ALUShamt(q4_shamt), .out_rd_addr(q4_rd),
    .out_reg_write(q4_out_reg_write), .bubble_count(q4_bubble)
  );

  typedef struct packed {
    logic [3:0]   op;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic [4:0]   sh;
    logic [4:0]   rd;
    logic         rw;
  } exp_t;

  exp_t        sb[$];
  bit          mv;
  int unsigned mb, mb4;
  int          n_chk = 0, n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] fwd(input logic [4:0] addr, input logic [N-1:0] rf);
    if (exmem_reg_write && exmem_rd == addr && addr != 0) return exmem_result;
    if (memwb_reg_write && memwb_rd == addr && addr != 0) return memwb_result;
    return rf;
  endfunction

  function automatic exp_t mk();
    exp_t e;
    e.op = in_alu_op; e.sh = in_shamt; e.rd = in_rd_addr; e.rw = in_reg_write;
    if (in_alu_op == 4'd4 || in_alu_op == 4'd5) begin
      e.a = fwd(in_rt_addr, in_rt_data);
      e.b = e.a;
    end else begin
      e.a = fwd(in_rs_addr, in_rs_data);
      e.b = (in_alu_src || in_alu_op == 4'd8) ? in_imm : fwd(in_rt_addr, in_rt_data);
    end
    return e;
  endfunction

  // one clock: check current outputs against model, advance model, cross the edge
  task automatic tick();
    bit rdy;
    #1;
    rdy = (!mv || out_ready) && !flush;
    chk("in_ready", in_ready, rdy);
    chk("out_valid", out_valid, mv);
    if (mv) begin
      if (sb.size() == 0) chk("sb_nonempty", 0, 1);
      else begin
        chk("ALUOperation", ALUOperation, sb[0].op);
        chk("A", A, sb[0].a);
        chk("B", B, sb[0].b);
        chk("ALUShamt", ALUShamt, sb[0].sh);
        chk("out_rd_addr", out_rd_addr, sb[0].rd);
        chk("out_reg_write", out_reg_write, sb[0].rw);
      end
    end
    chk("bubble_count", bubble_count, mb);
    chk("bubble_count4", q4_bubble, mb4);
    if (!(mv && out_ready)) begin
      if (mb != 32'hFFFF) mb++;
      if (mb4 != 15) mb4++;
    end
    if (mv && (out_ready || flush) && sb.size() != 0) void'(sb.pop_front());
    if (flush) begin mv = 0; sb.delete(); end
    else if (in_valid && rdy) begin sb.push_back(mk()); mv = 1; end
    else if (mv && out_ready) mv = 0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 0; flush = 0; out_ready = 1; in_alu_op = 0; in_alu_src = 0;
    in_reg_write = 0; in_rs_data = 0; in_rt_data = 0; in_imm = 0;
    in_rs_addr = 0; in_rt_addr = 0; in_rd_addr = 0; in_shamt = 0;
    exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
    memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
  endtask

  task automatic model_reset();
    mv = 0; mb = 0; mb4 = 0; sb.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_op"}, ALUOperation, 0);
    chk({tag, "_A"}, A, 0);
    chk({tag, "_B"}, B, 0);
    chk({tag, "_shamt"}, ALUShamt, 0);
    chk({tag, "_rd"}, out_rd_addr, 0);
    chk({tag, "_rw"}, out_reg_write, 0);
    chk({tag, "_bubble"}, bubble_count, 0);
    chk({tag, "_bubble4"}, q4_bubble, 0);
  endtask

  task automatic load(input logic [3:0] op, input logic [4:0] rs, input logic [N-1:0] rsd,
                      input logic [4:0] rt, input logic [N-1:0] rtd);
    in_valid = 1; in_alu_op = op; in_rs_addr = rs; in_rs_data = rsd;
    in_rt_addr = rt; in_rt_data = rtd; in_rd_addr = 5'd9; in_reg_write = 1;
  endtask

  initial begin
    idle();
    model_reset();
    reset = 0;
    #3;
    chk_zero("reset");
    @(negedge clk); @(negedge clk);
    reset = 1;

    // basic load, first edge after reset release
    load(4'd3, 5'd3, 32'h10, 5'd4, 32'h20);
    tick();
    in_valid = 0;
    chk("basic_valid", out_valid, 1);
    chk("basic_A", A, 32'h10);
    chk("basic_B", B, 32'h20);
    chk("basic_op", ALUOperation, 3);
    tick();

    // forwarding priority
    exmem_reg_write = 1; exmem_rd = 5; exmem_result = 32'hAAAA;
    memwb_reg_write = 1; memwb_rd = 5; memwb_result = 32'hBBBB;
    load(4'd3, 5'd5, 32'h55, 5'd6, 32'h66);
    tick();
    in_valid = 0;
    chk("fwd_exmem_A", A, 32'hAAAA);
    tick();
    exmem_rd = 0; memwb_rd = 0;
    load(4'd3, 5'd0, 32'h123, 5'd6, 32'h66);
    tick();
    in_valid = 0;
    chk("fwd_r0_A", A, 32'h123);
    tick();
    exmem_rd = 7; memwb_rd = 6;
    load(4'd1, 5'd2, 32'h1, 5'd6, 32'h66);
    tick();
    in_valid = 0;
    chk("fwd_memwb_B", B, 32'hBBBB);
    tick();
    idle();

    // backpressure: held three cycles, then next instruction loads
    load(4'd0, 5'd1, 32'h111, 5'd2, 32'h222);
    tick();
    load(4'd3, 5'd3, 32'h333, 5'd4, 32'h444);
    exmem_reg_write = 1; exmem_rd = 1; exmem_result = 32'hDEAD;
    out_ready = 0;
    repeat (3) tick();
    out_ready = 1;
    tick();
    in_valid = 0;
    chk("bp_next_A", A, 32'h333);
    tick();
    idle();

    // flush drops held and incoming
    load(4'd2, 5'd1, 32'h1, 5'd2, 32'h2);
    tick();
    load(4'd3, 5'd3, 32'hF00D, 5'd4, 32'h4);
    flush = 1; out_ready = 0;
    tick();
    idle();
    chk("flush_valid", out_valid, 0);
    repeat (2) tick();

    // shift and LUI routing
    load(4'd4, 5'd1, 32'h999, 5'd2, 32'h1);
    in_shamt = 4;
    tick();
    in_valid = 0;
    chk("sll_A", A, 32'h1);
    chk("sll_shamt", ALUShamt, 4);
    load(4'd8, 5'd1, 32'h999, 5'd2, 32'h77);
    in_imm = 32'h1234; in_alu_src = 0;
    tick();
    in_valid = 0;
    chk("lui_B", B, 32'h1234);
    tick();
    idle();

    // saturation of the small counter
    repeat (20) tick();
    chk("sat4", q4_bubble, 4'hF);

    // async reset mid-hold
    load(4'd3, 5'd3, 32'h10, 5'd4, 32'h20);
    tick();
    in_valid = 0; out_ready = 0;
    tick();
    #2 reset = 0;
    #1 chk_zero("async");
    @(negedge clk);
    reset = 1;
    model_reset();
    idle();
    tick();
    chk("post_reset_valid", out_valid, 0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 11) == 0);
      in_alu_op = 4'($urandom_range(0, 9));
      in_alu_src = $urandom_range(0, 1);
      in_reg_write = $urandom_range(0, 1);
      in_rs_addr = 5'($urandom_range(0, 5));
      in_rt_addr = 5'($urandom_range(0, 5));
      in_rd_addr = 5'($urandom);
      in_shamt = 5'($urandom);
      in_rs_data = $urandom; in_rt_data = $urandom; in_imm = $urandom;
      exmem_reg_write = $urandom_range(0, 1);
      exmem_rd = 5'($urandom_range(0, 5));
      exmem_result = $urandom;
      memwb_reg_write = $urandom_range(0, 1);
      memwb_rd = 5'($urandom_range(0, 5));
      memwb_result = $urandom;
      tick();
    end
    idle();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
